// File: rtl/gpio_protocol_rx.sv
// gpio_protocol_rx: receive side of the board-to-board GPIO nibble link.
// Synchronises the peer's lines and runs a four-phase req/ack handshake per
// nibble. It assembles the nibbles MSB-first into a word and offers each word
// through a valid/ready holding register. Stalled or broken frames are aborted
// and counted.
module gpio_protocol_rx #(
  parameter int NIBBLES     = 8,
  parameter int TIMEOUT     = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [3:0]             gpio_data,
  input  logic                   gpio_req,
  input  logic                   gpio_sof,
  input  logic                   gpio_state,
  output logic                   gpio_ack,
  output logic [4*NIBBLES-1:0]   word_out,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic                   peer_active,
  output logic                   err_pulse,
  output logic [7:0]             err_count
);

  localparam int WORD_W = 4 * NIBBLES;
  localparam int CNT_W  = $clog2(NIBBLES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NIBBLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACK      = 2'd1,
    ST_WAIT_REQ = 2'd2,
    ST_DELIVER  = 2'd3
  } state_e;

  // Abort counter increment that sticks at its maximum.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

  // Synchroniser chains; stage 0 samples the pins, the last stage is used.
  logic [SYNC_STAGES-1:0][3:0] data_sync_q;
  logic [SYNC_STAGES-1:0]      req_sync_q;
  logic [SYNC_STAGES-1:0]      sof_sync_q;
  logic [SYNC_STAGES-1:0]      state_sync_q;
  logic                        req_prev_q;

  logic [3:0] data_s;
  logic       req_s;
  logic       sof_s;
  logic       state_s;

  // FSM and datapath registers.
  state_e             state_q;
  logic               ack_q;
  logic [WORD_W-1:0]  shift_q;
  logic [CNT_W-1:0]   nib_cnt_q;
  logic [TMO_W-1:0]   tmo_q;
  logic               pending_q;   // last nibble captured, ack held back
  logic [WORD_W-1:0]  word_q;
  logic               valid_q;
  logic               err_pulse_q;
  logic [7:0]         err_cnt_q;

  logic rise_s;
  logic out_free_s;
  logic abort_s;

  assign data_s  = data_sync_q[SYNC_STAGES-1];
  assign req_s   = req_sync_q[SYNC_STAGES-1];
  assign sof_s   = sof_sync_q[SYNC_STAGES-1];
  assign state_s = state_sync_q[SYNC_STAGES-1];

  // Move every peer line through its synchroniser and delay req for edge detect.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_sync_q  <= '0;
      req_sync_q   <= '0;
      sof_sync_q   <= '0;
      state_sync_q <= '0;
      req_prev_q   <= 1'b0;
    end else begin
      data_sync_q[0]  <= gpio_data;
      req_sync_q[0]   <= gpio_req;
      sof_sync_q[0]   <= gpio_sof;
      state_sync_q[0] <= gpio_state;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        data_sync_q[i]  <= data_sync_q[i-1];
        req_sync_q[i]   <= req_sync_q[i-1];
        sof_sync_q[i]   <= sof_sync_q[i-1];
        state_sync_q[i] <= state_sync_q[i-1];
      end
      req_prev_q <= req_s;
    end
  end

  // Request edge, output-slot availability and frame-abort decision.
  always_comb begin
    rise_s     = req_s & ~req_prev_q;
    out_free_s = ~valid_q | word_ready;
    abort_s    = 1'b0;
    case (state_q)
      ST_ACK, ST_WAIT_REQ: abort_s = ~state_s | (tmo_q == TMO_LAST);
      ST_DELIVER:          abort_s = ~state_s;
      default:             abort_s = 1'b0;
    endcase
  end

  // Handshake FSM with word assembly, delivery, timeout and error counting.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ack_q       <= 1'b0;
      shift_q     <= '0;
      nib_cnt_q   <= '0;
      tmo_q       <= '0;
      pending_q   <= 1'b0;
      word_q      <= '0;
      valid_q     <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      err_pulse_q <= 1'b0;
      // Consumer handshake; a DELIVER below overrides this with a fresh word.
      if (valid_q && word_ready) begin
        valid_q <= 1'b0;
      end
      if (abort_s) begin
        // Abort wins over any request edge seen in the same cycle.
        state_q     <= ST_IDLE;
        ack_q       <= 1'b0;
        shift_q     <= '0;
        nib_cnt_q   <= '0;
        tmo_q       <= '0;
        pending_q   <= 1'b0;
        err_pulse_q <= 1'b1;
        err_cnt_q   <= sat_inc8(err_cnt_q);
      end else begin
        case (state_q)
          ST_IDLE: begin
            ack_q     <= 1'b0;
            nib_cnt_q <= '0;
            tmo_q     <= '0;
            if (rise_s && sof_s && state_s) begin
              shift_q   <= {{(WORD_W-4){1'b0}}, data_s};
              nib_cnt_q <= CNT_ONE;
              ack_q     <= 1'b1;
              state_q   <= ST_ACK;
            end
          end
          ST_ACK: begin
            if (!req_s) begin
              ack_q   <= 1'b0;
              tmo_q   <= '0;
              state_q <= (nib_cnt_q == CNT_FULL) ? ST_DELIVER : ST_WAIT_REQ;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end
          ST_WAIT_REQ: begin
            if (pending_q) begin
              // Timer frozen while the consumer still owns the output slot.
              if (out_free_s) begin
                pending_q <= 1'b0;
                ack_q     <= 1'b1;
                tmo_q     <= '0;
                state_q   <= ST_ACK;
              end
            end else if (rise_s && sof_s) begin
              // New frame mid-word: restart with this nibble, count the loss.
              shift_q     <= {{(WORD_W-4){1'b0}}, data_s};
              nib_cnt_q   <= CNT_ONE;
              ack_q       <= 1'b1;
              tmo_q       <= '0;
              state_q     <= ST_ACK;
              err_pulse_q <= 1'b1;
              err_cnt_q   <= sat_inc8(err_cnt_q);
            end else if (rise_s) begin
              shift_q   <= {shift_q[WORD_W-5:0], data_s};
              nib_cnt_q <= nib_cnt_q + CNT_W'(1);
              if ((nib_cnt_q == CNT_LAST) && !out_free_s) begin
                pending_q <= 1'b1;
              end else begin
                ack_q   <= 1'b1;
                tmo_q   <= '0;
                state_q <= ST_ACK;
              end
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end
          ST_DELIVER: begin
            word_q    <= shift_q;
            valid_q   <= 1'b1;
            nib_cnt_q <= '0;
            tmo_q     <= '0;
            state_q   <= ST_IDLE;
          end
          default: begin
            state_q   <= ST_IDLE;
            ack_q     <= 1'b0;
            nib_cnt_q <= '0;
            tmo_q     <= '0;
            pending_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign gpio_ack    = ack_q;
  assign word_out    = word_q;
  assign word_valid  = valid_q;
  assign peer_active = state_s;
  assign err_pulse   = err_pulse_q;
  assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_gpio_protocol_rx.sv
// Directed bench for gpio_protocol_rx: a peer BFM drives nibble handshakes, a
// transaction-level model holds the expected words and abort counts, and a
// per-cycle compare process checks delivered words, word hold and peer_active.
module tb_gpio_protocol_rx;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  gpio_data;
  logic        gpio_req;
  logic        gpio_sof;
  logic        gpio_state;
  logic        gpio_ack;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic        peer_active;
  logic        err_pulse;
  logic [7:0]  err_count;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];      // words the consumer must see, in order
  int          exp_err     = 0;
  int          exp_pulses  = 0;
  int          obs_pulses  = 0;
  int          valid_cycles = 0;
  logic [1:0]  state_hist = 2'b00;
  bit          started = 1'b0;
  logic        held = 1'b0;
  logic [31:0] held_word = 32'd0;

  gpio_protocol_rx #(.NIBBLES(8), .TIMEOUT(1000), .SYNC_STAGES(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .gpio_data   (gpio_data),
    .gpio_req    (gpio_req),
    .gpio_sof    (gpio_sof),
    .gpio_state  (gpio_state),
    .gpio_ack    (gpio_ack),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .peer_active (peer_active),
    .err_pulse   (err_pulse),
    .err_count   (err_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // peer_active must equal gpio_state as sampled two rising edges earlier.
  always @(posedge clock) begin
    if (reset) state_hist <= 2'b00;
    else       state_hist <= {state_hist[0], gpio_state};
  end

  // Per-cycle compare: word order, word hold, pulse tally, peer_active.
  always @(negedge clock) begin
    if (started) begin
      check("peer_active", {31'd0, peer_active}, {31'd0, state_hist[1]});
      if (held) begin
        check("hold_valid", {31'd0, word_valid}, 32'd1);
        check("hold_word", word_out, held_word);
      end
      if (word_valid) valid_cycles <= valid_cycles + 1;
      if (err_pulse)  obs_pulses   <= obs_pulses + 1;
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: got %h expected no word", word_out);
        end else begin
          check("word_out", word_out, exp_q.pop_front());
        end
      end
      held      <= word_valid && !word_ready && !reset;
      held_word <= word_out;
    end
  end

  // One four-phase handshake; ack must follow req by exactly 3 cycles.
  task automatic send_nibble(input logic [3:0] d, input logic sof, input string tag);
    int lat;
    gpio_data = d;
    gpio_sof  = sof;
    tick();
    gpio_req = 1'b1;
    lat = 0;
    while (!gpio_ack && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_ack_latency"}, 32'(lat), 32'd3);
    gpio_req = 1'b0;
    lat = 0;
    while (gpio_ack && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_ack_release"}, {31'd0, gpio_ack}, 32'd0);
    gpio_sof = 1'b0;
  endtask

  // First n nibbles of w, MSB first, sof on the first one.
  task automatic send_nibbles(input logic [31:0] w, input int n, input string tag);
    logic [3:0] nb;
    for (int i = 0; i < n; i++) begin
      nb = w[31-4*i -: 4];
      send_nibble(nb, (i == 0), tag);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int v0;
    bit withheld;

    reset = 1'b1; gpio_data = 4'h0; gpio_req = 1'b0; gpio_sof = 1'b0;
    gpio_state = 1'b0; word_ready = 1'b0;
    repeat (3) tick();
    check("rst_ack",       {31'd0, gpio_ack},    32'd0);
    check("rst_word_out",  word_out,             32'd0);
    check("rst_valid",     {31'd0, word_valid},  32'd0);
    check("rst_peer",      {31'd0, peer_active}, 32'd0);
    check("rst_err_pulse", {31'd0, err_pulse},   32'd0);
    check("rst_err_count", {24'd0, err_count},   32'd0);
    reset = 1'b0;
    started = 1'b1;
    gpio_state = 1'b1;
    repeat (4) tick();
    check("peer_up", {31'd0, peer_active}, 32'd1);

    // Basic word, consumer always ready.
    word_ready = 1'b1;
    v0 = valid_cycles;
    exp_q.push_back(32'hDEADBEEF);
    send_nibbles(32'hDEADBEEF, 8, "basic");
    repeat (4) tick();
    check("basic_drained", 32'(exp_q.size()), 32'd0);
    check("basic_valid_cycles", 32'(valid_cycles - v0), 32'd1);
    check("basic_err_count", {24'd0, err_count}, 32'd0);

    // Backpressure: first word held, last ack of second word withheld.
    word_ready = 1'b0;
    exp_q.push_back(32'h12345678);
    send_nibbles(32'h12345678, 8, "bp1");
    repeat (3) tick();
    check("bp_valid_held", {31'd0, word_valid}, 32'd1);
    check("bp_word_held", word_out, 32'h12345678);
    exp_q.push_back(32'hCAFEF00D);
    send_nibbles(32'hCAFEF00D, 7, "bp2");
    gpio_data = 4'hD;
    tick();
    gpio_req = 1'b1;
    withheld = 1'b1;
    repeat (30) begin
      tick();
      if (gpio_ack) withheld = 1'b0;
    end
    check("bp_ack_withheld", {31'd0, withheld}, 32'd1);
    check("bp_first_still_out", word_out, 32'h12345678);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    k = 0;
    while (!gpio_ack && k < 10) begin
      tick();
      k++;
    end
    check("bp_ack_after_ready", {31'd0, gpio_ack}, 32'd1);
    gpio_req = 1'b0;
    k = 0;
    while (gpio_ack && k < 20) begin
      tick();
      k++;
    end
    repeat (3) tick();
    check("bp_second_valid", {31'd0, word_valid}, 32'd1);
    check("bp_second_word", word_out, 32'hCAFEF00D);
    word_ready = 1'b1;
    repeat (2) tick();
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Timeout: three nibbles then silence.
    send_nibbles(32'h12300000, 3, "tmo");
    k = 0;
    while (!err_pulse && k < 1100) begin
      tick();
      k++;
    end
    check("tmo_cycles", 32'(k), 32'd1000);
    check("tmo_ack_low", {31'd0, gpio_ack}, 32'd0);
    exp_err++;
    exp_pulses++;
    tick();
    check("tmo_pulse_single", {31'd0, err_pulse}, 32'd0);
    check("tmo_err_count", {24'd0, err_count}, 32'(exp_err));
    exp_q.push_back(32'h0000000A);
    send_nibbles(32'h0000000A, 8, "tmo_next");
    repeat (4) tick();
    check("tmo_drained", 32'(exp_q.size()), 32'd0);

    // Resync: five nibbles, then a fresh sof frame.
    send_nibbles(32'h12345000, 5, "rs_part");
    exp_err++;
    exp_pulses++;
    exp_q.push_back(32'hA5A5A5A5);
    send_nibbles(32'hA5A5A5A5, 8, "rs_full");
    repeat (4) tick();
    check("rs_drained", 32'(exp_q.size()), 32'd0);
    check("rs_err_count", {24'd0, err_count}, 32'(exp_err));
    check("rs_pulses", 32'(obs_pulses), 32'(exp_pulses));

    // Peer disable mid-frame, then an orphan nibble without sof.
    send_nibbles(32'h77700000, 3, "dis");
    gpio_state = 1'b0;
    repeat (5) tick();
    exp_err++;
    exp_pulses++;
    check("dis_err_count", {24'd0, err_count}, 32'(exp_err));
    check("dis_ack_low", {31'd0, gpio_ack}, 32'd0);
    check("dis_pulses", 32'(obs_pulses), 32'(exp_pulses));
    gpio_state = 1'b1;
    repeat (4) tick();
    gpio_data = 4'h7;
    tick();
    gpio_req = 1'b1;
    withheld = 1'b1;
    repeat (10) begin
      tick();
      if (gpio_ack) withheld = 1'b0;
    end
    check("dis_nosof_ignored", {31'd0, withheld}, 32'd1);
    gpio_req = 1'b0;
    repeat (4) tick();
    check("dis_no_word", {31'd0, word_valid}, 32'd0);
    exp_q.push_back(32'h0BADF00D);
    send_nibbles(32'h0BADF00D, 8, "dis_next");
    repeat (4) tick();
    check("dis_drained", 32'(exp_q.size()), 32'd0);

    // Reset while in ACK with a word still held.
    word_ready = 1'b0;
    exp_q.push_back(32'h11111111);
    send_nibbles(32'h11111111, 8, "rm_held");
    repeat (3) tick();
    gpio_data = 4'h9;
    gpio_sof = 1'b1;
    tick();
    gpio_req = 1'b1;
    k = 0;
    while (!gpio_ack && k < 20) begin
      tick();
      k++;
    end
    check("rm_in_ack", {31'd0, gpio_ack}, 32'd1);
    reset = 1'b1;
    gpio_req = 1'b0;
    gpio_sof = 1'b0;
    tick();
    check("rm_ack", {31'd0, gpio_ack}, 32'd0);
    check("rm_valid", {31'd0, word_valid}, 32'd0);
    check("rm_err_count", {24'd0, err_count}, 32'd0);
    check("rm_word_out", word_out, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    exp_err = 0;
    repeat (5) tick();
    check("rm_stays_idle", {31'd0, word_valid}, 32'd0);

    // Saturation: 256 back-to-back resyncs plus one disable abort.
    word_ready = 1'b1;
    send_nibble(4'h1, 1'b1, "sat_first");
    for (int i = 0; i < 256; i++) begin
      send_nibble(4'h2, 1'b1, "sat");
    end
    exp_pulses += 256;
    repeat (2) tick();
    check("sat_err_count", {24'd0, err_count}, 32'd255);
    gpio_state = 1'b0;
    repeat (5) tick();
    exp_pulses++;
    check("sat_hold", {24'd0, err_count}, 32'd255);
    check("sat_pulses", 32'(obs_pulses), 32'(exp_pulses));
    check("final_no_words", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
